// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter: the pipeline result has priority, long-latency results wait in a FIFO.
// Define WB_BYPASS_EN to add youngest-entry bypass outputs (byp1/byp2) for decode.
module rf_wb_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     p_valid,
  input  logic [ADDR_W-1:0]        p_wR,
  input  logic [DATA_W-1:0]        p_wD,
  input  logic                     m_valid,
  output logic                     m_ready,
  input  logic [ADDR_W-1:0]        m_wR,
  input  logic [DATA_W-1:0]        m_wD,
  output logic                     rf_we,
  output logic [ADDR_W-1:0]        rf_wR,
  output logic [DATA_W-1:0]        rf_wD,
  input  logic [ADDR_W-1:0]        rR1,
  input  logic [ADDR_W-1:0]        rR2,
  output logic                     pend1,
  output logic                     pend2,
  output logic                     wb_hold,
  output logic [$clog2(DEPTH):0]   q_count
`ifdef WB_BYPASS_EN
  ,
  output logic                     byp1_hit,
  output logic                     byp2_hit,
  output logic [DATA_W-1:0]        byp1_data,
  output logic [DATA_W-1:0]        byp2_data
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(STARVE_MAX + 1);

  function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] c);
    return (c >= SW'(STARVE_MAX)) ? c : c + 1'b1;
  endfunction

  logic [DEPTH-1:0]  live_q, live_nxt;
  logic [ADDR_W-1:0] wr_q [DEPTH];
  logic [DATA_W-1:0] wd_q [DEPTH];
  logic [AW:0]       wptr, rptr;
  logic [AW-1:0]     widx, ridx;
  logic              full, empty, push, pipe_win, pop, starve;
  logic [SW-1:0]     starve_cnt;

  logic              vld_p1;
  logic [ADDR_W-1:0] wr_p1;
  logic [DATA_W-1:0] wd_p1;
  logic              hold_p1;

  assign widx     = wptr[AW-1:0];
  assign ridx     = rptr[AW-1:0];
  assign empty    = (wptr == rptr);
  assign full     = (wptr[AW] != rptr[AW]) && (widx == ridx);
  assign q_count  = wptr - rptr;
  assign m_ready  = !full;
  assign push     = m_valid && !full;
  assign pipe_win = p_valid && (p_wR != '0);
  assign pop      = !pipe_win && !empty;
  assign starve   = pipe_win && !empty;

  // Kill older same-register entries first; the slot written this edge is younger and stays live.
  always_comb begin
    live_nxt = live_q;
    if (pipe_win) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (live_q[i] && (wr_q[i] == p_wR)) live_nxt[i] = 1'b0;
      end
    end
    if (pop)  live_nxt[ridx] = 1'b0;
    if (push) live_nxt[widx] = (m_wR != '0);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      wr_q[widx] <= m_wR;
      wd_q[widx] <= m_wD;
    end
  end

  // Stage p1: registered RF write port and starvation hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr       <= '0;
      rptr       <= '0;
      live_q     <= '0;
      vld_p1     <= 1'b0;
      wr_p1      <= '0;
      wd_p1      <= '0;
      hold_p1    <= 1'b0;
      starve_cnt <= '0;
    end else begin
      live_q <= live_nxt;
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;

      if (pipe_win) begin
        vld_p1 <= 1'b1;
        wr_p1  <= p_wR;
        wd_p1  <= p_wD;
      end else if (pop) begin
        vld_p1 <= live_q[ridx];
        wr_p1  <= wr_q[ridx];
        wd_p1  <= wd_q[ridx];
      end else begin
        vld_p1 <= 1'b0;
      end

      if (pop) begin
        starve_cnt <= '0;
        hold_p1    <= 1'b0;
      end else if (starve) begin
        starve_cnt <= sat_inc(starve_cnt);
        if (sat_inc(starve_cnt) >= SW'(STARVE_MAX)) hold_p1 <= 1'b1;
      end
    end
  end

  assign rf_we   = vld_p1;
  assign rf_wR   = wr_p1;
  assign rf_wD   = wd_p1;
  assign wb_hold = hold_p1;

  always_comb begin
    pend1 = 1'b0;
    pend2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live_q[i] && (wr_q[i] == rR1) && (rR1 != '0)) pend1 = 1'b1;
      if (live_q[i] && (wr_q[i] == rR2) && (rR2 != '0)) pend2 = 1'b1;
    end
  end

`ifdef WB_BYPASS_EN
  // Walk oldest to youngest so the last match left standing is the youngest value.
  always_comb begin
    logic [AW-1:0] idx;
    byp1_hit  = 1'b0;
    byp2_hit  = 1'b0;
    byp1_data = '0;
    byp2_data = '0;
    idx       = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = ridx + AW'(k);
      if (live_q[idx] && (wr_q[idx] == rR1) && (rR1 != '0)) begin
        byp1_hit  = 1'b1;
        byp1_data = wd_q[idx];
      end
      if (live_q[idx] && (wr_q[idx] == rR2) && (rR2 != '0)) begin
        byp2_hit  = 1'b1;
        byp2_data = wd_q[idx];
      end
    end
  end
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed steps plus a short random burst, checked cycle by cycle
// against a queue-based reference model whose expected RF writes go through a scoreboard.
module tb_rf_wb_arbiter;
  localparam int DATA_W = 32, ADDR_W = 5, DEPTH = 4, STARVE_MAX = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic p_valid, m_valid, m_ready, rf_we, pend1, pend2, wb_hold;
  logic [ADDR_W-1:0] p_wR, m_wR, rf_wR, rR1, rR2;
  logic [DATA_W-1:0] p_wD, m_wD, rf_wD;
  logic [$clog2(DEPTH):0] q_count;
`ifdef WB_BYPASS_EN
  logic byp1_hit, byp2_hit;
  logic [DATA_W-1:0] byp1_data, byp2_data;
`endif

  always #5 clk = ~clk;

  rf_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .p_valid(p_valid), .p_wR(p_wR), .p_wD(p_wD),
    .m_valid(m_valid), .m_ready(m_ready), .m_wR(m_wR), .m_wD(m_wD),
    .rf_we(rf_we), .rf_wR(rf_wR), .rf_wD(rf_wD),
    .rR1(rR1), .rR2(rR2), .pend1(pend1), .pend2(pend2),
    .wb_hold(wb_hold), .q_count(q_count)
`ifdef WB_BYPASS_EN
    , .byp1_hit(byp1_hit), .byp2_hit(byp2_hit), .byp1_data(byp1_data), .byp2_data(byp2_data)
`endif
  );

  typedef struct { bit live; logic [ADDR_W-1:0] wr; logic [DATA_W-1:0] wd; } ent_t;
  typedef struct { bit we; logic [ADDR_W-1:0] wr; logic [DATA_W-1:0] wd; } exp_t;

  ent_t mq[$];
  exp_t sb[$];
  int errors = 0, checks = 0;
  int cnt_m = 0;
  bit hold_m = 1'b0;
  logic [ADDR_W-1:0] last_wr = '0;
  logic [DATA_W-1:0] last_wd = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit pend_m(input logic [ADDR_W-1:0] r);
    foreach (mq[i]) if (mq[i].live && mq[i].wr == r && r != '0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [DATA_W:0] byp_m(input logic [ADDR_W-1:0] r);
    logic [DATA_W:0] res;
    res = '0;
    foreach (mq[i]) if (mq[i].live && mq[i].wr == r && r != '0) res = {1'b1, mq[i].wd};
    return res;
  endfunction

  // Advance the model one edge from the current inputs, push the expected write, clock, compare.
  task automatic tick();
    exp_t e, o;
    ent_t h, n;
    int sz;
    bit win, popd;
    logic [DATA_W:0] b;
    sz   = mq.size();
    win  = p_valid && (p_wR != '0);
    popd = 1'b0;
    e.we = 1'b0; e.wr = last_wr; e.wd = last_wd;
    if (win) begin
      e.we = 1'b1; e.wr = p_wR; e.wd = p_wD;
      for (int i = 0; i < mq.size(); i++) if (mq[i].wr == p_wR) mq[i].live = 1'b0;
    end else if (sz > 0) begin
      h = mq.pop_front();
      e.we = h.live; e.wr = h.wr; e.wd = h.wd;
      popd = 1'b1;
    end
    if (m_valid && sz < DEPTH) begin
      n.live = (m_wR != '0); n.wr = m_wR; n.wd = m_wD;
      mq.push_back(n);
    end
    if (popd) begin
      cnt_m = 0; hold_m = 1'b0;
    end else if (win && sz > 0) begin
      if (cnt_m < STARVE_MAX) cnt_m++;
      if (cnt_m >= STARVE_MAX) hold_m = 1'b1;
    end
    last_wr = e.wr; last_wd = e.wd;
    sb.push_back(e);
    @(posedge clk);
    #1;
    o = sb.pop_front();
    chk("rf_we", 64'(rf_we), 64'(o.we));
    chk("rf_wR", 64'(rf_wR), 64'(o.wr));
    chk("rf_wD", 64'(rf_wD), 64'(o.wd));
    chk("wb_hold", 64'(wb_hold), 64'(hold_m));
    chk("q_count", 64'(q_count), 64'(mq.size()));
    chk("m_ready", 64'(m_ready), 64'(mq.size() < DEPTH));
    chk("pend1", 64'(pend1), 64'(pend_m(rR1)));
    chk("pend2", 64'(pend2), 64'(pend_m(rR2)));
`ifdef WB_BYPASS_EN
    b = byp_m(rR1);
    chk("byp1_hit", 64'(byp1_hit), 64'(b[DATA_W]));
    if (b[DATA_W]) chk("byp1_data", 64'(byp1_data), 64'(b[DATA_W-1:0]));
    b = byp_m(rR2);
    chk("byp2_hit", 64'(byp2_hit), 64'(b[DATA_W]));
    if (b[DATA_W]) chk("byp2_data", 64'(byp2_data), 64'(b[DATA_W-1:0]));
`else
    b = '0;
`endif
  endtask

  task automatic drv(input bit pv, input int pr, input int pd, input bit mv, input int mr, input int md);
    p_valid = pv; p_wR = ADDR_W'(pr); p_wD = DATA_W'(pd);
    m_valid = mv; m_wR = ADDR_W'(mr); m_wD = DATA_W'(md);
    tick();
  endtask

  initial begin
    p_valid = 1'b0; m_valid = 1'b0; p_wR = '0; p_wD = '0; m_wR = '0; m_wD = '0;
    rR1 = '0; rR2 = '0;
    #12;
    chk("rst_we", 64'(rf_we), 64'(0));
    chk("rst_wR", 64'(rf_wR), 64'(0));
    chk("rst_wD", 64'(rf_wD), 64'(0));
    chk("rst_hold", 64'(wb_hold), 64'(0));
    chk("rst_qc", 64'(q_count), 64'(0));
    chk("rst_ready", 64'(m_ready), 64'(1));
    rst_n = 1'b1;

    // Pipeline only, then a pipeline write to r0
    drv(1, 5, 'hDEAD, 0, 0, 0);
    chk("pipe_we", 64'(rf_we), 64'(1));
    chk("pipe_wR", 64'(rf_wR), 64'(5));
    chk("pipe_wD", 64'(rf_wD), 64'('hDEAD));
    drv(1, 0, 'hBEEF, 0, 0, 0);
    chk("pipe_r0_we", 64'(rf_we), 64'(0));

    // Fill to full under continuous pipeline traffic, then drain in order
    for (int i = 0; i < 4; i++) drv(1, 1, 100 + i, 1, 7 + i, 'h700 + i);
    chk("full_qc", 64'(q_count), 64'(4));
    chk("full_ready", 64'(m_ready), 64'(0));
    drv(1, 1, 'h55, 1, 11, 'hBAD);
    chk("full_refuse_qc", 64'(q_count), 64'(4));
    for (int i = 0; i < 4; i++) begin
      drv(0, 0, 0, 0, 0, 0);
      chk("drain_we", 64'(rf_we), 64'(1));
      chk("drain_wR", 64'(rf_wR), 64'(7 + i));
      chk("drain_wD", 64'(rf_wD), 64'('h700 + i));
    end
    chk("drain_qc", 64'(q_count), 64'(0));

    // WAW kill
    rR1 = 5'd3;
    drv(0, 0, 0, 1, 3, 'h11);
    chk("waw_pend_on", 64'(pend1), 64'(1));
    drv(1, 3, 'h22, 0, 0, 0);
    chk("waw_wD", 64'(rf_wD), 64'('h22));
    chk("waw_pend_off", 64'(pend1), 64'(0));
    drv(0, 0, 0, 0, 0, 0);
    chk("waw_dead_we", 64'(rf_we), 64'(0));
    chk("waw_dead_qc", 64'(q_count), 64'(0));

    // Push and kill to the same register at the same edge: the push survives
    rR2 = 5'd6;
    drv(1, 6, 'h66, 1, 6, 'h67);
    chk("kvp_pend", 64'(pend2), 64'(1));
    drv(0, 0, 0, 0, 0, 0);
    chk("kvp_we", 64'(rf_we), 64'(1));
    chk("kvp_wD", 64'(rf_wD), 64'('h67));

    // Starvation
    drv(1, 2, 'h20, 1, 12, 'hC0);
    for (int i = 0; i < 8; i++) begin
      drv(1, 2, 'h21 + i, 0, 0, 0);
      if (i == 6) chk("starve_hold_7", 64'(wb_hold), 64'(0));
    end
    chk("starve_hold_8", 64'(wb_hold), 64'(1));
    drv(0, 0, 0, 0, 0, 0);
    chk("starve_pop_wR", 64'(rf_wR), 64'(12));
    chk("starve_release", 64'(wb_hold), 64'(0));

    // Two values for r4 queued: the younger one is the bypass source
    rR1 = 5'd4;
    drv(1, 1, 1, 1, 4, 'hA);
    drv(1, 1, 2, 1, 4, 'hB);
    chk("dup_pend", 64'(pend1), 64'(1));
`ifdef WB_BYPASS_EN
    chk("byp_hit", 64'(byp1_hit), 64'(1));
    chk("byp_data", 64'(byp1_data), 64'('hB));
`endif
    drv(0, 0, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 0);
    chk("dup_last_wD", 64'(rf_wD), 64'('hB));

    // Reset mid-traffic with three entries queued
    rR1 = 5'd13; rR2 = 5'd14;
    for (int i = 0; i < 3; i++) drv(1, 1, i, 1, 13 + i, 'hE0 + i);
    chk("pre_rst_qc", 64'(q_count), 64'(3));
    p_valid = 1'b0; m_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_we", 64'(rf_we), 64'(0));
    chk("mid_rst_qc", 64'(q_count), 64'(0));
    chk("mid_rst_ready", 64'(m_ready), 64'(1));
    chk("mid_rst_pend1", 64'(pend1), 64'(0));
    chk("mid_rst_pend2", 64'(pend2), 64'(0));
    mq.delete();
    cnt_m = 0; hold_m = 1'b0; last_wr = '0; last_wd = '0;
    #1 rst_n = 1'b1;
    drv(0, 0, 0, 0, 0, 0);

    // Random mix over a small register range so kills and r0 writes occur
    for (int i = 0; i < 80; i++) begin
      rR1 = ADDR_W'($urandom_range(0, 7));
      rR2 = ADDR_W'($urandom_range(0, 7));
      drv(($urandom_range(0, 2) != 0), int'($urandom_range(0, 7)), int'($urandom),
          ($urandom_range(0, 1) != 0), int'($urandom_range(0, 7)), int'($urandom));
    end
    for (int i = 0; i < 6; i++) drv(0, 0, 0, 0, 0, 0);
    chk("final_qc", 64'(q_count), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
